// File: rtl/spi_flash_responder_if.sv
// SPI flash pin bundle plus the backing-memory port of the responder.
//   flash_csb/sck/mosi : controller -> responder SPI pins
//   flash_miso/_oe     : responder -> controller data pin and its drive enable
//   memAddress/memReadEnable/memDataRead : byte-wide synchronous memory port
//   active/lastCommand : status (chip selected, last complete opcode)
// Modport slave is the responder side; master is the controller/memory side.
interface spi_flash_responder_if #(
  parameter int unsigned ADDR_WIDTH = 24
);
  logic                  flash_csb;
  logic                  flash_sck;
  logic                  flash_mosi;
  logic                  flash_miso;
  logic                  flash_miso_oe;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic                  memReadEnable;
  logic [7:0]            memDataRead;
  logic                  active;
  logic [7:0]            lastCommand;

  modport slave (
    input  flash_csb, flash_sck, flash_mosi, memDataRead,
    output flash_miso, flash_miso_oe, memAddress, memReadEnable, active, lastCommand
  );

  modport master (
    output flash_csb, flash_sck, flash_mosi, memDataRead,
    input  flash_miso, flash_miso_oe, memAddress, memReadEnable, active, lastCommand
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI NOR flash responder (mode 0, single-bit IO). Decodes READ (0x03),
// FAST_READ (0x0B, 8 dummy bits) and JEDEC-ID (0x9F) and streams bytes from a
// byte-wide synchronous memory on miso; other opcodes are ignored.
// Ports:
//   clk   : system clock, all SPI pins are oversampled on it
//   rst_n : asynchronous reset, active low
//   bus   : spi_flash_responder_if.slave (SPI pins, memory port, status)
module spi_flash_responder #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
  input logic                  clk,
  input logic                  rst_n,
  spi_flash_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

  state_t state_q, state_d;

  logic csb_s1, csb_s2, csb_d;
  logic sck_s1, sck_s2, sck_d;
  logic mosi_s1, mosi_s2;
  logic csb_fall, csb_rise, sck_rise, sck_fall;

  logic [4:0]            bit_cnt;
  logic [22:0]           in_sr;
  logic [23:0]           in_next;
  logic                  fast_q;
  logic                  id_mode_q;
  logic [1:0]            id_idx;
  logic [7:0]            id_byte;
  logic [7:0]            out_sr;
  logic                  miso_q;
  logic [2:0]            fall_cnt;
  logic                  ren_q;
  logic                  load_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            last_cmd_q;
  logic                  oe;
  logic                  cmd_done, addr_done, dummy_done, data_fall;

  // Input synchronisers; csb idles high so its chain resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_s1  <= 1'b1;
      csb_s2  <= 1'b1;
      csb_d   <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      csb_s1  <= bus.flash_csb;
      csb_s2  <= csb_s1;
      csb_d   <= csb_s2;
      sck_s1  <= bus.flash_sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      mosi_s1 <= bus.flash_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign csb_fall = csb_d & ~csb_s2;
  assign csb_rise = ~csb_d & csb_s2;
  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign in_next  = {in_sr, mosi_s2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && csb_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (csb_fall) state_d = CMD;
        CMD:   if (sck_rise && bit_cnt == 5'd7) begin
                 case (in_next[7:0])
                   8'h03, 8'h0B: state_d = ADDR;
                   8'h9F:        state_d = DATA;
                   default:      state_d = IGNORE;
                 endcase
               end
        ADDR:  if (sck_rise && bit_cnt == 5'd23) state_d = fast_q ? DUMMY : DATA;
        DUMMY: if (sck_rise && bit_cnt == 5'd7) state_d = DATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    oe                = (state_q == DATA) && !csb_s2;
    bus.flash_miso_oe = oe;
    bus.flash_miso    = oe & miso_q;
  end

  assign cmd_done   = (state_q == CMD) && (state_d != CMD) && (state_d != IDLE);
  assign addr_done  = (state_q == ADDR) && (state_d == DUMMY || state_d == DATA);
  assign dummy_done = (state_q == DUMMY) && (state_d == DATA);
  assign data_fall  = (state_q == DATA) && sck_fall;

  always_comb begin
    case (id_idx)
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = '0;
    endcase
  end

  // Each byte's 8th miso fall prefetches the next byte: the read strobe goes
  // out the following clk and the data lands in out_sr a clk later, well
  // before the next sck fall needs bit 7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      in_sr      <= '0;
      fast_q     <= 1'b0;
      id_mode_q  <= 1'b0;
      id_idx     <= '0;
      out_sr     <= '0;
      miso_q     <= 1'b0;
      fall_cnt   <= '0;
      ren_q      <= 1'b0;
      load_q     <= 1'b0;
      mem_addr_q <= '0;
      last_cmd_q <= '0;
    end else begin
      ren_q  <= 1'b0;
      load_q <= ren_q;
      if (sck_rise) in_sr <= in_next[22:0];
      if (state_d != state_q) bit_cnt <= '0;
      else if (sck_rise)      bit_cnt <= bit_cnt + 5'd1;

      if (csb_fall) begin
        out_sr    <= '0;
        miso_q    <= 1'b0;
        fall_cnt  <= '0;
        fast_q    <= 1'b0;
        id_mode_q <= 1'b0;
      end

      if (cmd_done) begin
        last_cmd_q <= in_next[7:0];
        fast_q     <= (in_next[7:0] == 8'h0B);
        id_mode_q  <= (in_next[7:0] == 8'h9F);
        if (in_next[7:0] == 8'h9F) begin
          out_sr <= JEDEC_ID[23:16];
          id_idx <= 2'd1;
        end
      end

      if (addr_done) mem_addr_q <= in_next[ADDR_WIDTH-1:0];
      if ((addr_done && !fast_q) || dummy_done) ren_q <= 1'b1;

      if (data_fall) begin
        miso_q   <= out_sr[7];
        fall_cnt <= fall_cnt + 3'd1;
        if (fall_cnt == 3'd7 && id_mode_q) begin
          out_sr <= id_byte;
          if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
        end else begin
          out_sr <= {out_sr[6:0], 1'b0};
          if (fall_cnt == 3'd7) begin
            mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
            ren_q      <= 1'b1;
          end
        end
      end

      if (load_q) out_sr <= bus.memDataRead;
    end
  end

  assign bus.memAddress    = mem_addr_q;
  assign bus.memReadEnable = ren_q;
  assign bus.active        = ~csb_s2;
  assign bus.lastCommand   = last_cmd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomised self-checking bench for spi_flash_responder: a bus-level SPI
// controller, a synchronous memory whose content is a fixed function of the
// address, and a transaction-level reference model of the expected bytes,
// memory address, read-strobe count and status.
module tb_spi_flash_responder;
  localparam int unsigned AW   = 24;
  localparam int unsigned HALF = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_flash_responder_if #(.ADDR_WIDTH(AW)) bus ();

  spi_flash_responder #(.ADDR_WIDTH(AW), .JEDEC_ID(24'hEF4018)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ 8'hA5 ^ a[15:8] ^ a[23:16];
  endfunction

  function automatic logic [7:0] id_ref(input int unsigned n);
    case (n)
      0:       return 8'hEF;
      1:       return 8'h40;
      2:       return 8'h18;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk)
    if (bus.memReadEnable) bus.memDataRead <= mem_byte(bus.memAddress);

  int unsigned ren_cnt = 0;
  int unsigned quiet_bad = 0;
  always @(posedge clk) begin
    if (bus.memReadEnable) ren_cnt++;
    if (!bus.flash_miso_oe && bus.flash_miso) quiet_bad++;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [23:0] exp_addr = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int unsigned nbits,
                          output logic [7:0] rx, output logic oe_all, output logic oe_any);
    rx = '0; oe_all = 1'b1; oe_any = 1'b0;
    for (int unsigned i = 0; i < nbits; i++) begin
      bus.flash_mosi = tx[3'(7 - i)];
      half_wait();
      rx     = {rx[6:0], bus.flash_miso};
      oe_all = oe_all & bus.flash_miso_oe;
      oe_any = oe_any | bus.flash_miso_oe;
      bus.flash_sck = 1'b1;
      half_wait();
      bus.flash_sck = 1'b0;
    end
  endtask

  // One csb-low transaction: opcode, optional address/dummy, nbytes full data
  // bytes, then tail_bits extra clocks before csb is raised (abort mid-byte).
  task automatic run_txn(input logic [7:0] op, input logic [23:0] addr,
                         input int unsigned nbytes, input int unsigned tail_bits);
    logic [7:0] rx;
    logic oe_all, oe_any, is_read, is_id;
    int unsigned r0, fetches;
    is_read = (op == 8'h03) || (op == 8'h0B);
    is_id   = (op == 8'h9F);
    r0 = ren_cnt;
    bus.flash_csb = 1'b0;
    half_wait();
    check_val("active_low_csb", 32'(bus.active), 32'd1);
    spi_bits(op, 8, rx, oe_all, oe_any);
    check_val("cmd_oe", 32'(oe_any), 32'd0);
    if (is_read) begin
      for (int k = 2; k >= 0; k--) spi_bits(addr[8*k +: 8], 8, rx, oe_all, oe_any);
      check_val("addr_oe", 32'(oe_any), 32'd0);
      if (op == 8'h0B) begin
        spi_bits(8'($urandom), 8, rx, oe_all, oe_any);
        check_val("dummy_oe", 32'(oe_any), 32'd0);
      end
    end
    for (int unsigned b = 0; b < nbytes; b++) begin
      spi_bits(8'($urandom), 8, rx, oe_all, oe_any);
      if (is_read) begin
        check_val("read_byte", 32'(rx), 32'(mem_byte(addr + 24'(b))));
        check_val("read_oe", 32'(oe_all), 32'd1);
      end else if (is_id) begin
        check_val("id_byte", 32'(rx), 32'(id_ref(b)));
        check_val("id_oe", 32'(oe_all), 32'd1);
      end else begin
        check_val("ignore_oe", 32'(oe_any), 32'd0);
      end
    end
    if (tail_bits != 0) spi_bits(8'($urandom), tail_bits, rx, oe_all, oe_any);
    bus.flash_csb = 1'b1;
    repeat (6) @(negedge clk);
    // One fetch at the end of the address phase plus one per 8 miso falls.
    fetches = is_read ? 1 + (1 + 8 * nbytes + tail_bits) / 8 : 0;
    if (is_read) exp_addr = addr + 24'(fetches - 1);
    check_val("oe_after_csb", 32'(bus.flash_miso_oe), 32'd0);
    check_val("active_idle", 32'(bus.active), 32'd0);
    check_val("last_cmd", 32'(bus.lastCommand), 32'(op));
    check_val("mem_addr", 32'(bus.memAddress), 32'(exp_addr));
    check_val("ren_count", ren_cnt - r0, fetches);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_oe"}, 32'(bus.flash_miso_oe), 32'd0);
    check_val({tag, "_miso"}, 32'(bus.flash_miso), 32'd0);
    check_val({tag, "_active"}, 32'(bus.active), 32'd0);
    check_val({tag, "_lastcmd"}, 32'(bus.lastCommand), 32'd0);
    check_val({tag, "_addr"}, 32'(bus.memAddress), 32'd0);
    check_val({tag, "_ren"}, 32'(bus.memReadEnable), 32'd0);
  endtask

  initial begin
    logic [7:0] rx, op;
    logic oe_all, oe_any;
    int unsigned r0, sel, tail;

    bus.flash_csb  = 1'b1;
    bus.flash_sck  = 1'b0;
    bus.flash_mosi = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    r0 = ren_cnt;
    repeat (20) @(negedge clk);
    check_val("idle_ren", ren_cnt - r0, 32'd0);
    check_val("idle_active", 32'(bus.active), 32'd0);

    run_txn(8'h03, 24'h000010, 4, 0);
    run_txn(8'h0B, 24'hFFFFFE, 4, 0);
    run_txn(8'h9F, 24'h0, 5, 0);
    run_txn(8'hAB, 24'h0, 2, 0);
    run_txn(8'h03, 24'h00ABCD, 2, 0);
    run_txn(8'h03, 24'h000200, 1, 3);
    run_txn(8'h03, 24'h000100, 1, 0);

    // Reset in the middle of the address phase.
    bus.flash_csb = 1'b0;
    half_wait();
    spi_bits(8'h03, 8, rx, oe_all, oe_any);
    spi_bits(8'h12, 8, rx, oe_all, oe_any);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("midaddr_reset");
    bus.flash_csb = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_addr = '0;
    repeat (6) @(negedge clk);
    run_txn(8'h03, 24'h123456, 2, 0);

    for (int unsigned t = 0; t < 25; t++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: op = 8'h03;
        1: op = 8'h0B;
        2: op = 8'h9F;
        default: begin
          op = 8'($urandom);
          while (op == 8'h03 || op == 8'h0B || op == 8'h9F) op = 8'($urandom);
        end
      endcase
      tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_txn(op, 24'($urandom), $urandom_range(1, 5), tail);
    end

    check_val("miso_quiet_when_undriven", quiet_bad, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
